// File: rtl/rr_encoder.sv
// Round-robin priority encoder: multi-hot req -> registered binary index + one-hot grant.
// Latency 1 cycle; output register holds (req ignored) while out_valid && !out_ready.
module rr_encoder #(
    parameter int N = 3,
    parameter int M = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [M-1:0] req,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [N-1:0] out_idx,
    output logic [M-1:0] grant
);

    if (M != (1 << N)) begin : g_bad_width
        $error("rr_encoder: M must equal 2**N");
    end

    logic [N-1:0]   ptr_q, ptr_d;
    logic           valid_q, valid_d;
    logic [N-1:0]   idx_q, idx_d;
    logic [M-1:0]   grant_q, grant_d;

    logic           load;
    logic [2*M-1:0] req_dbl;
    logic [M-1:0]   req_rot;
    logic [N-1:0]   offset;
    logic [N-1:0]   sel;

    // Rotate req so bit 0 is the requester at ptr; the lowest set bit is then the winner.
    always_comb begin
        req_dbl = {req, req} >> ptr_q;
        req_rot = req_dbl[M-1:0];
        offset  = '0;
        for (int j = M - 1; j >= 0; j--) begin
            if (req_rot[j]) begin
                offset = N'(j);
            end
        end
        // Index arithmetic wraps naturally because M == 2**N.
        sel = ptr_q + offset;
    end

    assign load = !valid_q || out_ready;

    always_comb begin
        ptr_d   = ptr_q;
        valid_d = valid_q;
        idx_d   = idx_q;
        grant_d = grant_q;
        if (load) begin
            if (|req) begin
                valid_d = 1'b1;
                idx_d   = sel;
                grant_d = M'(1) << sel;
                ptr_d   = sel + N'(1);
            end else begin
                valid_d = 1'b0;
                grant_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q   <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            grant_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
            grant_q <= grant_d;
        end
    end

    assign out_valid = valid_q;
    assign out_idx   = idx_q;
    assign grant     = grant_q;

endmodule

// File: tb/tb_rr_encoder.sv
// Self-checking bench for rr_encoder: directed scenarios plus random traffic vs a scan-based model.
module tb_rr_encoder;
    localparam int N = 3;
    localparam int M = 8;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [M-1:0] req;
    logic         out_ready;
    logic         out_valid;
    logic [N-1:0] out_idx;
    logic [M-1:0] grant;

    int n_chk  = 0;
    int n_pass = 0;

    // reference state
    int m_ptr;
    bit m_valid;
    int m_idx;

    rr_encoder #(.N(N), .M(M)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_idx   (out_idx),
        .grant     (grant)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_ptr   = 0;
        m_valid = 0;
        m_idx   = 0;
    endtask

    // One clock edge of the arbiter, computed directly from the circular-scan rule.
    task automatic model_edge();
        bit found;
        if (!reset_n) begin
            model_reset();
            return;
        end
        if (m_valid && !out_ready) return;
        found = 0;
        for (int k = 0; k < M; k++) begin
            int i;
            i = (m_ptr + k) % M;
            if (!found && req[i]) begin
                found   = 1;
                m_idx   = i;
                m_ptr   = (i + 1) % M;
                m_valid = 1;
            end
        end
        if (!found) m_valid = 0;
    endtask

    task automatic check_outputs(input string tag);
        logic [M-1:0] exp_grant;
        exp_grant = m_valid ? (M'(1) << m_idx) : '0;
        chk({tag, ".valid"}, 32'(out_valid), 32'(m_valid));
        chk({tag, ".idx"},   32'(out_idx),   32'(m_idx));
        chk({tag, ".grant"}, 32'(grant),     32'(exp_grant));
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(tag);
    endtask

    task automatic do_reset();
        #1;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_outputs("reset_async");
        cycle("in_reset");
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n   = 1'b1;
        req       = '0;
        out_ready = 1'b0;
        #1;
        reset_n = 1'b0;
        #2;
        model_reset();
        check_outputs("por");
        cycle("por_hold");
        reset_n = 1'b1;

        // Full request vector: strict 0..7,0 sequence without bubbles.
        req = 8'hFF; out_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            cycle("rr_all");
            chk("rr_seq_idx", 32'(out_idx), 32'(k % M));
            chk("rr_seq_valid", 32'(out_valid), 32'd1);
        end

        // Rotation skipping unrequested slots.
        do_reset();
        req = 8'b0010_0100; out_ready = 1'b1;
        cycle("skip"); chk("skip_idx0", 32'(out_idx), 32'd2);
        cycle("skip"); chk("skip_idx1", 32'(out_idx), 32'd5);
        cycle("skip"); chk("skip_idx2", 32'(out_idx), 32'd2);

        // Backpressure: output frozen, req changes ignored during stall.
        do_reset();
        req = 8'h18; out_ready = 1'b1;
        cycle("bp_load"); chk("bp_load_idx", 32'(out_idx), 32'd3);
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k == 2) req = 8'h01;
            cycle("bp_stall");
            chk("bp_stall_idx",   32'(out_idx), 32'd3);
            chk("bp_stall_grant", 32'(grant),   32'h08);
        end
        out_ready = 1'b1;
        cycle("bp_release"); chk("bp_release_idx", 32'(out_idx), 32'd0);

        // Empty drain then wrap boundary at ptr=7.
        do_reset();
        req = 8'h40; out_ready = 1'b1;
        cycle("drain"); chk("drain_idx", 32'(out_idx), 32'd6);
        req = 8'h00;
        cycle("drain_empty");
        chk("drain_valid", 32'(out_valid), 32'd0);
        chk("drain_grant", 32'(grant), 32'h00);
        req = 8'h81;
        cycle("wrap"); chk("wrap_idx7", 32'(out_idx), 32'd7);
        cycle("wrap"); chk("wrap_idx0", 32'(out_idx), 32'd0);

        // Asynchronous reset mid-cycle while holding a valid selection.
        out_ready = 1'b0;
        cycle("pre_arst");
        chk("pre_arst_valid", 32'(out_valid), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_idx",   32'(out_idx),   32'd0);
        chk("arst_grant", 32'(grant),     32'h00);
        cycle("arst_hold");
        reset_n = 1'b1;
        req = 8'h80; out_ready = 1'b1;
        cycle("post_arst");
        chk("post_arst_idx",   32'(out_idx), 32'd7);
        chk("post_arst_grant", 32'(grant),   32'h80);

        // Random traffic with random backpressure and occasional resets.
        for (int k = 0; k < 600; k++) begin
            case ($urandom_range(0, 3))
                0:       req = '0;
                1:       req = M'(1) << $urandom_range(0, M - 1);
                default: req = M'($urandom);
            endcase
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end
            cycle("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got %0d/%0d", n_pass, n_chk);
        $fatal(1);
    end
endmodule
